// File: rtl/usb_rx_phy_pkg.sv
// usb_rx_phy_pkg: line codes, FSM states and timing constants for the full-speed USB receiver.
package usb_rx_phy_pkg;
  localparam int CLOCKS_PER_BIT = 4;
  localparam int RESET_SE0_CYCLES = 120;
  localparam int MIN_SYNC_ZEROS = 3;
  localparam int PHASE_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_SE1 = 2'b11;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, WAIT_J} rx_state_e;
endpackage

// File: rtl/usb_rx_bit_recovery.sv
// usb_rx_bit_recovery: synchronises D+/D- and recovers a mid-bit sample strobe from the 4x clock.
module usb_rx_bit_recovery
  import usb_rx_phy_pkg::*;
(
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       usb_dp,
  input  logic       usb_dn,
  output logic       bit_strobe,
  output logic [1:0] line_state
);
  logic [1:0] meta, prev;
  logic [PHASE_W-1:0] phase;
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      meta <= LINE_J;
      line_state <= LINE_J;
      prev <= LINE_J;
      phase <= '0;
    end else begin
      meta <= {usb_dp, usb_dn};
      line_state <= meta;
      prev <= line_state;
      phase <= (line_state != prev || phase == PHASE_W'(CLOCKS_PER_BIT - 1)) ? '0 : phase + 1'b1;
    end
  end
  // never sample on the very cycle an edge arrives, before the phase has realigned
  assign bit_strobe = phase == PHASE_W'(CLOCKS_PER_BIT / 2) && line_state == prev;
endmodule

// File: rtl/usb_rx_phy.sv
// usb_rx_phy: full-speed USB receive front-end: NRZI decode, sync strip, unstuff, EOP and bus-reset detect.
module usb_rx_phy
  import usb_rx_phy_pkg::*;
(
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       usb_dp,
  input  logic       usb_dn,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       usb_reset
);
  rx_state_e state, state_n;
  logic bit_strobe, nrzi;
  logic [1:0] line, prev, prev_n;
  logic [2:0] zeros, zeros_n, ones, ones_n, bits, bits_n;
  logic [7:0] shift, shift_n, data_n;
  logic active_n, valid_n, eop_n, error_n;
  logic [6:0] se0_count;
  usb_rx_bit_recovery u_rec (
    .clock48(clock48),
    .reset_n(reset_n),
    .usb_dp(usb_dp),
    .usb_dn(usb_dn),
    .bit_strobe(bit_strobe),
    .line_state(line)
  );
  assign nrzi = line == prev;
  assign usb_reset = line == LINE_SE0 && se0_count == 7'(RESET_SE0_CYCLES);
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) se0_count <= '0;
    else se0_count <= line != LINE_SE0 ? '0 : se0_count == 7'(RESET_SE0_CYCLES) ? se0_count : se0_count + 7'd1;
  end
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      prev <= LINE_J;
      {zeros, ones, bits} <= '0;
      {shift, rx_data} <= '0;
      {rx_active, rx_valid, rx_eop, rx_error} <= '0;
    end else begin
      prev <= prev_n;
      {zeros, ones, bits} <= {zeros_n, ones_n, bits_n};
      {shift, rx_data} <= {shift_n, data_n};
      {rx_active, rx_valid, rx_eop, rx_error} <= {active_n, valid_n, eop_n, error_n};
    end
  end
  always_comb begin
    state_n = state;
    prev_n = bit_strobe ? line : prev;
    zeros_n = zeros;
    ones_n = ones;
    bits_n = bits;
    shift_n = shift;
    data_n = rx_data;
    active_n = rx_active;
    {valid_n, eop_n, error_n} = '0;
    if (usb_reset) begin
      state_n = WAIT_J;
      active_n = 1'b0;
    end else if (bit_strobe) begin
      case (state)
        IDLE: if (line == LINE_K && prev == LINE_J) begin
          state_n = SYNC;
          zeros_n = '0;
        end
        SYNC: if (line == LINE_SE0 || line == LINE_SE1) begin
          error_n = 1'b1;
          state_n = WAIT_J;
        end else if (!nrzi) zeros_n = zeros == 3'd7 ? zeros : zeros + 3'd1;
        else if (zeros >= 3'(MIN_SYNC_ZEROS)) begin
          state_n = DATA;
          active_n = 1'b1;
          ones_n = 3'd1;
          bits_n = '0;
        end else begin
          error_n = 1'b1;
          state_n = WAIT_J;
        end
        DATA: if (line == LINE_SE0 || line == LINE_SE1) begin
          eop_n = line == LINE_SE0 && bits == '0;
          error_n = !eop_n;
          active_n = 1'b0;
          state_n = WAIT_J;
        end else if (ones == 3'd6) begin
          // six 1s in a row: this bit is the stuffed 0 and carries no data
          ones_n = '0;
          if (nrzi) begin
            error_n = 1'b1;
            active_n = 1'b0;
            state_n = WAIT_J;
          end
        end else begin
          shift_n = {nrzi, shift[7:1]};
          bits_n = bits + 3'd1;
          ones_n = nrzi ? ones + 3'd1 : '0;
          if (bits == 3'd7) begin
            valid_n = 1'b1;
            data_n = shift_n;
          end
        end
        WAIT_J: if (line == LINE_J) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_rx_phy.sv
// tb_usb_rx_phy: directed packets driven as NRZI pad levels, received bytes and strobes checked against hand values.
module tb_usb_rx_phy;
  import usb_rx_phy_pkg::*;
  logic clock48 = 1'b0, reset_n = 1'b0, usb_dp = 1'b1, usb_dn = 1'b0;
  logic rx_active, rx_valid, rx_eop, rx_error, usb_reset;
  logic [7:0] rx_data;
  int tests = 0, fails = 0, neop = 0, nerr = 0, ones = 0;
  logic [7:0] got[$];
  logic level = 1'b1;
  usb_rx_phy dut (
    .clock48(clock48),
    .reset_n(reset_n),
    .usb_dp(usb_dp),
    .usb_dn(usb_dn),
    .rx_active(rx_active),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_eop(rx_eop),
    .rx_error(rx_error),
    .usb_reset(usb_reset)
  );
  always #10 clock48 = ~clock48;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clock48) begin
    if (rx_valid) got.push_back(rx_data);
    if (rx_eop) neop++;
    if (rx_error) nerr++;
    if (rx_valid || rx_eop || rx_error) chk("exclusive", 32'($countones({rx_valid, rx_eop, rx_error})), 1);
  end
  task automatic drive(input logic dp, input logic dn, input int nbits);
    usb_dp = dp;
    usb_dn = dn;
    repeat (nbits * CLOCKS_PER_BIT) @(negedge clock48);
  endtask
  task automatic line_bit(input logic b);
    if (!b) level = ~level;
    drive(level, ~level, 1);
  endtask
  task automatic send_bits(input logic [31:0] v, input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      line_bit(v[i]);
      ones = v[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        line_bit(1'b0);
        ones = 0;
      end
    end
  endtask
  task automatic start_packet();
    level = 1'b1;
    drive(1'b1, 1'b0, 2);
    send_bits(32'(SYNC_PATTERN), 8, 1'b0);
  endtask
  task automatic end_packet();
    drive(1'b0, 1'b0, 2);
    level = 1'b1;
    drive(1'b1, 1'b0, 3);
  endtask
  task automatic expect_rx(input string name, input int n, input logic [31:0] bytes, input int eop, input int err);
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk({name, "_byte"}, got[i], 32'(bytes[8*i+:8]));
    chk({name, "_eop"}, neop, eop);
    chk({name, "_err"}, nerr, err);
    chk({name, "_active"}, rx_active, 0);
    got.delete();
    neop = 0;
    nerr = 0;
  endtask
  initial begin
    repeat (3) @(negedge clock48);
    chk("rst_active", rx_active, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_eop", rx_eop, 0);
    chk("rst_error", rx_error, 0);
    chk("rst_usb_reset", usb_reset, 0);
    chk("rst_data", rx_data, 0);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4);
    start_packet(); send_bits(32'hD2, 8, 1'b1); end_packet();
    expect_rx("ack", 1, 32'hD2, 1, 0);
    start_packet(); send_bits(32'h00012D, 24, 1'b1); end_packet();
    expect_rx("setup", 3, 32'h00012D, 1, 0);
    start_packet(); send_bits(32'hFFFFC3, 24, 1'b1); end_packet();
    expect_rx("stuffed", 3, 32'hFFFFC3, 1, 0);
    start_packet(); send_bits(32'h7F, 7, 1'b0); end_packet();
    expect_rx("seven_ones", 0, 0, 0, 1);
    start_packet(); send_bits(32'h5A, 8, 1'b1); end_packet();
    expect_rx("after_err", 1, 32'h5A, 1, 0);
    start_packet(); send_bits(32'h3A5, 12, 1'b1); end_packet();
    expect_rx("short_eop", 1, 32'hA5, 0, 1);
    usb_dp = 1'b0;
    usb_dn = 1'b0;
    repeat (121) @(posedge clock48);
    @(negedge clock48);
    chk("busrst_early", usb_reset, 0);
    @(negedge clock48);
    chk("busrst_set", usb_reset, 1);
    repeat (200) @(negedge clock48);
    chk("busrst_hold", usb_reset, 1);
    usb_dp = 1'b1;
    @(negedge clock48);
    chk("busrst_j1", usb_reset, 1);
    @(negedge clock48);
    chk("busrst_clr", usb_reset, 0);
    drive(1'b1, 1'b0, 4);
    expect_rx("busrst", 0, 0, 0, 0);
    start_packet(); send_bits(32'h0F, 5, 1'b1);
    chk("mid_active", rx_active, 1);
    reset_n = 1'b0;
    #1;
    chk("async_active", rx_active, 0);
    chk("async_data", rx_data, 0);
    chk("async_valid", rx_valid, 0);
    level = 1'b1;
    usb_dp = 1'b1;
    usb_dn = 1'b0;
    repeat (2) @(negedge clock48);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4);
    got.delete();
    neop = 0;
    nerr = 0;
    start_packet(); send_bits(32'h3C96, 16, 1'b1); end_packet();
    expect_rx("post_rst", 2, 32'h3C96, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
